// File: rtl/ras_ckpt_pkg.sv
// Shared defaults and stack-operation decode for the checkpointed return address stack.
package ras_ckpt_pkg;

   localparam int unsigned RAS_SIZE      = 8;
   localparam int unsigned RAS_CKPT_SIZE = 8;
   localparam int unsigned RAS_ADDR_W    = 32;

   typedef enum logic [1:0] {
      STK_HOLD,
      STK_PUSH,
      STK_POP,
      STK_REPL
   } stk_op_e;

   // push+pop replaces the top, except on an empty stack where it degrades to a plain push
   function automatic stk_op_e stk_op_decode(input logic push, input logic pop, input logic empty);
      if (push && pop) return empty ? STK_PUSH : STK_REPL;
      if (push)        return STK_PUSH;
      if (pop && !empty) return STK_POP;
      return STK_HOLD;
   endfunction

endpackage

// File: rtl/ras_ckpt_fifo.sv
// In-order checkpoint FIFO: snapshot storage with allocate, release-oldest and truncate-to-tag.
module ras_ckpt_fifo #(
   parameter int unsigned NUM_CKPT = 8,
   parameter int unsigned SNAP_W   = 36
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        alloc_req_i,
   input  logic                        rel_i,
   input  logic                        recover_i,
   input  logic [$clog2(NUM_CKPT)-1:0] recover_tag_i,
   input  logic [SNAP_W-1:0]           snap_wdata_i,
   output logic [SNAP_W-1:0]           snap_rdata_o,
   output logic                        alloc_gnt_o,
   output logic [$clog2(NUM_CKPT)-1:0] alloc_tag_o,
   output logic                        full_o,
   output logic [$clog2(NUM_CKPT):0]   count_o
`ifdef DEBUG
   ,
   output logic [$clog2(NUM_CKPT)-1:0] head_o,
   output logic [$clog2(NUM_CKPT)-1:0] tail_o
`endif
);

   localparam int unsigned TAG_W = $clog2(NUM_CKPT);
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(NUM_CKPT);

   logic [SNAP_W-1:0] snap_q [NUM_CKPT];
   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;
   logic [TAG_W-1:0]  live_span;
   logic              rel_ok;

   assign full_o       = (count_q == FULL_CNT);
   assign alloc_gnt_o  = alloc_req_i & ~full_o & ~recover_i;
   assign alloc_tag_o  = tail_q;
   assign count_o      = count_q;
   assign snap_rdata_o = snap_q[recover_tag_i];
   assign rel_ok       = rel_i & (count_q != '0);
   assign live_span    = recover_tag_i - head_q;

`ifdef DEBUG
   assign head_o = head_q;
   assign tail_o = tail_q;
`endif

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rel_ok) head_d = head_q + 1'b1;
      if (recover_i) begin
         // Slots from recover_tag onward are discarded; the oldest may also retire this cycle
         tail_d  = recover_tag_i;
         count_d = (TAG_W+1)'(live_span) - (TAG_W+1)'(rel_ok);
      end else begin
         if (alloc_gnt_o) tail_d = tail_q + 1'b1;
         count_d = count_q + (TAG_W+1)'(alloc_gnt_o) - (TAG_W+1)'(rel_ok);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < NUM_CKPT; i++) snap_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (alloc_gnt_o) snap_q[tail_q] <= snap_wdata_i;
      end
   end

endmodule

// File: rtl/ras_ckpt.sv
// Return address stack with per-branch checkpoints; restores tos/cnt/top from a checkpoint on mispredict.
module ras_ckpt
   import ras_ckpt_pkg::*;
#(
   parameter int unsigned DEPTH    = RAS_SIZE,
   parameter int unsigned ADDR_W   = RAS_ADDR_W,
   parameter int unsigned NUM_CKPT = RAS_CKPT_SIZE
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        push,
   input  logic [ADDR_W-1:0]           push_addr,
   input  logic                        pop,
   output logic                        top_valid,
   output logic [ADDR_W-1:0]           top_addr,
   input  logic                        ckpt_req,
   output logic                        ckpt_gnt,
   output logic [$clog2(NUM_CKPT)-1:0] ckpt_tag,
   input  logic                        rel,
   input  logic                        recover,
   input  logic [$clog2(NUM_CKPT)-1:0] recover_tag,
   output logic                        ckpt_full,
   output logic [$clog2(NUM_CKPT):0]   ckpt_count
`ifdef DEBUG
   ,
   output logic [DEPTH*ADDR_W-1:0]     ras_stack_out,
   output logic [$clog2(DEPTH)-1:0]    ras_tos_out,
   output logic [$clog2(DEPTH):0]      ras_cnt_out,
   output logic [$clog2(NUM_CKPT)-1:0] ckpt_head_out,
   output logic [$clog2(NUM_CKPT)-1:0] ckpt_tail_out
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [PTR_W-1:0]  tos;
      logic [PTR_W:0]    cnt;
      logic [ADDR_W-1:0] top;
   } ras_ckpt_t;

   localparam int unsigned SNAP_W = $bits(ras_ckpt_t);

   logic [ADDR_W-1:0] stack_q [DEPTH];
   logic [PTR_W-1:0]  tos_q, tos_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] wr_data;
   stk_op_e           op;
   ras_ckpt_t         snap_w, snap_r;
   logic [SNAP_W-1:0] snap_rdata;

   assign top_valid = (cnt_q != '0);
   assign top_addr  = stack_q[tos_q];
   assign op        = stk_op_decode(push, pop, cnt_q == '0);
   assign snap_w    = '{tos: tos_q, cnt: cnt_q, top: stack_q[tos_q]};
   assign snap_r    = ras_ckpt_t'(snap_rdata);

   ras_ckpt_fifo #(
      .NUM_CKPT (NUM_CKPT),
      .SNAP_W   (SNAP_W)
   ) u_fifo (
      .clock         (clock),
      .reset         (reset),
      .alloc_req_i   (ckpt_req),
      .rel_i         (rel),
      .recover_i     (recover),
      .recover_tag_i (recover_tag),
      .snap_wdata_i  (snap_w),
      .snap_rdata_o  (snap_rdata),
      .alloc_gnt_o   (ckpt_gnt),
      .alloc_tag_o   (ckpt_tag),
      .full_o        (ckpt_full),
      .count_o       (ckpt_count)
`ifdef DEBUG
      ,
      .head_o        (ckpt_head_out),
      .tail_o        (ckpt_tail_out)
`endif
   );

   always_comb begin
      tos_d   = tos_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = tos_q;
      wr_data = push_addr;
      if (recover) begin
         // Rewriting the saved top undoes a pop-then-push that clobbered that slot
         tos_d   = snap_r.tos;
         cnt_d   = snap_r.cnt;
         wr_en   = 1'b1;
         wr_idx  = snap_r.tos;
         wr_data = snap_r.top;
      end else begin
         case (op)
            STK_PUSH: begin
               tos_d  = tos_q + 1'b1;
               wr_en  = 1'b1;
               wr_idx = tos_q + 1'b1;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            STK_POP: begin
               tos_d = tos_q - 1'b1;
               cnt_d = cnt_q - 1'b1;
            end
            STK_REPL: wr_en = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tos_q <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      end else begin
         tos_q <= tos_d;
         cnt_q <= cnt_d;
         if (wr_en) stack_q[wr_idx] <= wr_data;
      end
   end

`ifdef DEBUG
   always_comb begin
      ras_stack_out = '0;
      for (int unsigned i = 0; i < DEPTH; i++) ras_stack_out[i*ADDR_W +: ADDR_W] = stack_q[i];
   end
   assign ras_tos_out = tos_q;
   assign ras_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt: a queue-based reference model predicts every cycle's outputs.
module tb_ras_ckpt;

   localparam int unsigned D  = 8;
   localparam int unsigned AW = 32;
   localparam int unsigned NC = 8;
   localparam int unsigned TW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          push = 1'b0, pop = 1'b0, ckpt_req = 1'b0, rel = 1'b0, recover = 1'b0;
   logic [AW-1:0] push_addr = '0;
   logic [TW-1:0] recover_tag = '0;
   logic          top_valid, ckpt_gnt, ckpt_full;
   logic [AW-1:0] top_addr;
   logic [TW-1:0] ckpt_tag;
   logic [TW:0]   ckpt_count;

   always #5 clock = ~clock;

   ras_ckpt #(.DEPTH(D), .ADDR_W(AW), .NUM_CKPT(NC)) dut (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .push_addr   (push_addr),
      .pop         (pop),
      .top_valid   (top_valid),
      .top_addr    (top_addr),
      .ckpt_req    (ckpt_req),
      .ckpt_gnt    (ckpt_gnt),
      .ckpt_tag    (ckpt_tag),
      .rel         (rel),
      .recover     (recover),
      .recover_tag (recover_tag),
      .ckpt_full   (ckpt_full),
      .ckpt_count  (ckpt_count)
   );

   typedef struct {
      bit          tv;
      logic [31:0] ta;
      bit          gnt;
      int          tag;
      bit          full;
      int          cnt;
   } exp_t;

   typedef struct {
      int          tag;
      int          tos;
      int          cnt;
      logic [31:0] top;
   } snap_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          done = 0;

   // reference model: circular stack by index arithmetic, checkpoints as an ordered queue
   logic [31:0] m_stk [D];
   int          m_tos, m_cnt, m_tail;
   snap_t       m_ck[$];
   bit          m_known = 0;

   task automatic model_reset();
      for (int i = 0; i < D; i++) m_stk[i] = '0;
      m_tos = 0; m_cnt = 0; m_tail = 0;
      m_ck.delete();
      m_known = 1;
   endtask

   task automatic cyc(input bit rs, input bit ps, input logic [31:0] a, input bit pp,
                      input bit rq, input bit rl, input bit rc, input int t);
      exp_t  e;
      snap_t s;
      int    idx;
      bit    rel_ok, gnt;
      @(negedge clock);
      reset = rs; push = ps; push_addr = a; pop = pp;
      ckpt_req = rq; rel = rl; recover = rc; recover_tag = TW'(t);
      gnt = rq && (m_ck.size() != NC) && !rc;
      if (m_known) begin
         e.tv = (m_cnt != 0); e.ta = m_stk[m_tos];
         e.gnt = gnt; e.tag = m_tail;
         e.full = (m_ck.size() == NC); e.cnt = m_ck.size();
         sb.push_back(e);
      end
      if (rs) begin
         model_reset();
      end else if (m_known) begin
         rel_ok = rl && (m_ck.size() > 0);
         if (rc) begin
            idx = -1;
            foreach (m_ck[k]) if (m_ck[k].tag == t) idx = k;
            if (idx < 0 || (rel_ok && idx == 0)) begin
               $display("FAIL stimulus: illegal recover tag %0d", t);
               n_bad++;
               idx = 0;
            end
            s = m_ck[idx];
            m_tos = s.tos; m_cnt = s.cnt; m_stk[s.tos] = s.top;
            while (m_ck.size() > idx) m_ck.delete(m_ck.size() - 1);
            m_tail = t;
            if (rel_ok) void'(m_ck.pop_front());
         end else begin
            if (rel_ok) void'(m_ck.pop_front());
            if (gnt) begin
               s.tag = m_tail; s.tos = m_tos; s.cnt = m_cnt; s.top = m_stk[m_tos];
               m_ck.push_back(s);
               m_tail = (m_tail + 1) % NC;
            end
            if (ps && pp && m_cnt != 0) begin
               m_stk[m_tos] = a;
            end else if (ps) begin
               m_tos = (m_tos + 1) % D;
               m_stk[m_tos] = a;
               if (m_cnt < D) m_cnt++;
            end else if (pp && m_cnt != 0) begin
               m_tos = (m_tos + D - 1) % D;
               m_cnt--;
            end
         end
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic rst();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic do_push(input logic [31:0] a);
      cyc(0, 1, a, 0, 0, 0, 0, 0);
   endtask
   task automatic do_pop();
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor: outputs are sampled mid-cycle, after the inputs for that cycle have settled
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("top_valid", 32'(top_valid), 32'(e.tv));
            check("top_addr", top_addr, e.ta);
            check("ckpt_gnt", 32'(ckpt_gnt), 32'(e.gnt));
            check("ckpt_full", 32'(ckpt_full), 32'(e.full));
            check("ckpt_count", 32'(ckpt_count), 32'(e.cnt));
            if (e.gnt) check("ckpt_tag", 32'(ckpt_tag), 32'(e.tag));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      bit rs, ps, pp, rq, rl, rc;
      int t, idx;
      logic [31:0] a;

      rst(); idle();
      do_push(32'h100); do_push(32'h200); do_push(32'h300);
      repeat (4) do_pop();
      idle();

      rst();
      for (int k = 1; k <= 9; k++) do_push(32'(k * 16));
      repeat (9) do_pop();
      idle();

      rst();
      do_push(32'hA0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      do_pop();
      do_push(32'hB0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      idle();

      rst();
      repeat (8) cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 3);
      idle();

      rst();
      do_push(32'h40);
      cyc(0, 1, 32'h50, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 1, 32'h77, 0, 0, 0, 1, 0);
      cyc(0, 1, 32'h60, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 1, 32'h88, 1, 0, 0, 0, 0);
      do_push(32'h99);
      rst();
      idle();

      for (int i = 0; i < 2500; i++) begin
         rs = ($urandom_range(0, 299) == 0);
         ps = ($urandom_range(0, 2) == 0);
         pp = ($urandom_range(0, 2) == 0);
         rq = ($urandom_range(0, 1) == 0);
         rl = ($urandom_range(0, 2) == 0);
         a  = $urandom;
         rc = 0; t = 0;
         if (m_ck.size() > 0 && $urandom_range(0, 9) == 0) begin
            idx = $urandom_range(0, m_ck.size() - 1);
            if (idx == 0) rl = 0;
            rc = 1;
            t  = m_ck[idx].tag;
         end
         cyc(rs, ps, a, pp, rq, rl, rc, t);
      end
      idle();

      done = 1;
      repeat (3) @(negedge clock);
      #4;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
